// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - multi-lane dot-product MAC engine with multi-beat accumulation
// Optional feature macro: CONV_MAC_SAT_EN (saturating accumulation; default build wraps modulo 2^RES_W)
module conv_mac_engine #(
    parameter int WIDTH = 64,
    parameter int LEN   = 4,
    parameter int LANES = 2,
    parameter int RES_W = 2*WIDTH+8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN*WIDTH-1:0]   kernel,
    input  logic [LEN*WIDTH-1:0]   data,
    input  logic                   in_signed,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [RES_W-1:0]       result,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int P  = LEN / LANES;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
`ifdef CONV_MAC_SAT_EN
    // Guard bits so one pass of LANES products plus acc cannot overflow before clamping
    localparam int GB = $clog2(LANES+1) + 1;
`else
    localparam int GB = 0;
`endif
    localparam int SUM_W = RES_W + GB;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t               state_q, state_d;
    logic [LEN*WIDTH-1:0] kernel_q, data_q;
    logic                 last_q;
    logic                 grp_signed;
    logic                 first_q;
    logic [PW-1:0]        pass_q;
    logic [RES_W-1:0]     acc_q;
    logic [RES_W-1:0]     acc_next;
    logic                 in_ready_q, out_valid_q;
    logic [RES_W-1:0]     result_q;

    logic [SUM_W-1:0]     sum;
    logic [WIDTH-1:0]     kop, dop;
    logic [2*WIDTH-1:0]   kext, dext, prod;
    int                   idx;

    logic accept;
    logic final_pass;

    assign accept     = in_valid && in_ready_q;
    assign final_pass = (pass_q == PW'(P-1));

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // One pass: acc plus the LANES products selected by the pass counter, extended per group sign
    always_comb begin
        idx  = 0;
        kop  = '0;
        dop  = '0;
        kext = '0;
        dext = '0;
        prod = '0;
`ifdef CONV_MAC_SAT_EN
        sum  = {{GB{grp_signed & acc_q[RES_W-1]}}, acc_q};
`else
        sum  = acc_q;
`endif
        for (int l = 0; l < LANES; l++) begin
            idx  = int'(pass_q) * LANES + l;
            kop  = kernel_q[idx*WIDTH +: WIDTH];
            dop  = data_q[idx*WIDTH +: WIDTH];
            kext = {{WIDTH{grp_signed & kop[WIDTH-1]}}, kop};
            dext = {{WIDTH{grp_signed & dop[WIDTH-1]}}, dop};
            prod = kext * dext;
            sum  = sum + {{(SUM_W-2*WIDTH){grp_signed & prod[2*WIDTH-1]}}, prod};
        end
    end

`ifdef CONV_MAC_SAT_EN
    localparam logic [SUM_W-1:0] SAT_MAX_S = {{(GB+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic [SUM_W-1:0] SAT_MIN_S = {{(GB+1){1'b1}}, {(RES_W-1){1'b0}}};

    // Clamp the widened pass sum back into RES_W according to the group's signedness
    always_comb begin
        acc_next = sum[RES_W-1:0];
        if (grp_signed) begin
            if ($signed(sum) > $signed(SAT_MAX_S))
                acc_next = {1'b0, {(RES_W-1){1'b1}}};
            else if ($signed(sum) < $signed(SAT_MIN_S))
                acc_next = {1'b1, {(RES_W-1){1'b0}}};
        end else if (|sum[SUM_W-1:RES_W]) begin
            acc_next = {RES_W{1'b1}};
        end
    end
`else
    // Plain modulo-2^RES_W accumulation
    always_comb begin
        acc_next = sum;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (final_pass) state_d = last_q ? HOLD : IDLE;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath, handshake flags and accumulator updates keyed to the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_q    <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            grp_signed  <= 1'b0;
            first_q     <= 1'b1;
            pass_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        kernel_q   <= kernel;
                        data_q     <= data;
                        last_q     <= in_last;
                        if (first_q)
                            grp_signed <= in_signed;
                        first_q    <= 1'b0;
                        pass_q     <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q  <= acc_next;
                    pass_q <= pass_q + PW'(1);
                    if (final_pass) begin
                        if (last_q) begin
                            result_q    <= acc_next;
                            out_valid_q <= 1'b1;
                        end else begin
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        first_q     <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb/tb_conv_mac_engine.sv - directed self-checking bench for conv_mac_engine
module tb_conv_mac_engine;

    localparam int WIDTH = 8;
    localparam int LEN   = 4;
    localparam int LANES = 2;
    localparam int RES_W = 2*WIDTH+8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [LEN*WIDTH-1:0] kernel;
    logic [LEN*WIDTH-1:0] data;
    logic                 in_signed;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [RES_W-1:0]     result;
    logic                 out_valid;
    logic                 out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_mac_engine #(.WIDTH(WIDTH), .LEN(LEN), .LANES(LANES), .RES_W(RES_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .kernel    (kernel),
        .data      (data),
        .in_signed (in_signed),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [31:0] pk(int a0, int a1, int a2, int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, present one beat for a single accepting edge
    task automatic send(logic [31:0] k, logic [31:0] d, logic s, logic l);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        kernel    = k;
        data      = d;
        in_signed = s;
        in_last   = l;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check result, then complete the output handshake
    task automatic expect_result(string tag, logic [RES_W-1:0] exp);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, {8'd0, result}, {8'd0, exp});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_hs_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic             stable;
    logic [RES_W-1:0] wrap_exp;

    initial begin
        rst       = 1'b1;
        kernel    = '0;
        data      = '0;
        in_signed = 1'b0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {8'd0, result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned single beat with cycle-accurate latency checks: 5+12+21+32 = 70
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b1);
        chk("t1_ready_low", {31'd0, in_ready}, 32'd0);
        chk("t1_valid_e0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_e1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_e2", {31'd0, out_valid}, 32'd1);
        chk("t1_result", {8'd0, result}, 32'd70);
        chk("t1_ready_hold", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_hs_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_result_kept", {8'd0, result}, 32'd70);

        // Signed single beat: -5 - 12 - 21 + 32 = -6
        send(pk(-1, 2, -3, 4), pk(5, -6, 7, 8), 1'b1, 1'b1);
        expect_result("t2_signed", 24'hFFFFFA);

        // Signed group continues with in_signed=0 on beat 2: -6 + (-1*2) = -8
        send(pk(-1, 2, -3, 4), pk(5, -6, 7, 8), 1'b1, 1'b0);
        send(pk(-1, 0, 0, 0), pk(2, 0, 0, 0), 1'b0, 1'b1);
        expect_result("t2_sticky_signed", 24'hFFFFF8);

        // Two-beat unsigned group: 4 + 24 = 28, no result after beat 1
        send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_mid_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("t3_beat1_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_beat1_ready", {31'd0, in_ready}, 32'd1);
        send(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 1'b0, 1'b1);
        expect_result("t3_two_beat", 24'd28);

        // Backpressure: hold for 10 cycles while in_valid pulses are ignored
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        stable    = 1'b1;
        kernel    = pk(50, 50, 50, 50);
        data      = pk(50, 50, 50, 50);
        in_last   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 24'd70 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("t4_stable", {31'd0, stable}, 32'd1);
        expect_result("t4_bp", 24'd70);
        send(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b0, 1'b1);
        expect_result("t4_after", 24'd8);

        // Reset during the second CALC pass discards the partial sum
        send(pk(9, 9, 9, 9), pk(9, 9, 9, 9), 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_result", {8'd0, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0, 1'b1);
        expect_result("t5_fresh", 24'd4);

        // 512 beats of 255*255*4 = 0x7F00800 total
`ifdef CONV_MAC_SAT_EN
        wrap_exp = 24'hFFFFFF;
`else
        wrap_exp = 24'hF00800;
`endif
        for (int b = 0; b < 512; b++)
            send(pk(255, 255, 255, 255), pk(255, 255, 255, 255), 1'b0, b == 511);
        expect_result("t6_wrap", wrap_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
